// File: rtl/aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// aes_inv_key_schedule : AES-128 key schedule walked backwards from the
// round-10 key, emitting round keys 10..0 one per valid/ready handshake.
// Revision: 1.0
// ============================================================================
module aes_inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic [3:0]   round_out,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // SubWord(RotWord(w)): rotate left by one byte, then substitute each byte.
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0]  w0_prev, w1_prev, w2_prev, w3_prev;
  logic [127:0] key_prev;

  // Undo one forward expansion step; w3' must exist before w0' can be recovered.
  always_comb begin
    w3_prev  = key_q[31:0]  ^ key_q[63:32];
    w2_prev  = key_q[63:32] ^ key_q[95:64];
    w1_prev  = key_q[95:64] ^ key_q[127:96];
    w0_prev  = key_q[127:96] ^ sub_rot(w3_prev) ^ {rcon(round_q), 24'h0};
    key_prev = {w0_prev, w1_prev, w2_prev, w3_prev};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = 4'd10;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (valid_q && key_ready) begin
          if (round_q != 4'd0) begin
            key_d   = key_prev;
            round_d = round_q - 4'd1;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      key_q   <= 128'h0;
      round_q <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign key_out   = key_q;
  assign round_out = round_q;
  assign key_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// tb_aes_inv_key_schedule : bench for the backwards AES-128 key schedule,
// using a word-array expansion model with a GF(2^8)-derived S-box.
// Revision: 1.0
// ============================================================================
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_ready = 1'b0;
  logic [127:0] key_out;
  logic [3:0]   round_out;
  logic         key_valid;
  logic         busy;
  logic         done;

  aes_inv_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .key_ready (key_ready),
    .key_out   (key_out),
    .round_out (round_out),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [7:0]   rc [11];
  logic [127:0] ref_rk [11];
  logic [127:0] cap [11];

  typedef struct {
    logic [127:0] k10;
    int           round;
    logic [127:0] expect_key;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rc[i] = xt(rc[i-1]);
  endtask

  function automatic logic [31:0] temp_word(input logic [31:0] prev, input int idx);
    logic [31:0] r;
    if (idx % 4 != 0) return prev;
    r = {prev[23:0], prev[31:24]};
    return {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]} ^ {rc[idx/4], 24'h0};
  endfunction

  task automatic compute_ref(input logic [127:0] k10);
    logic [31:0] w [44];
    for (int j = 0; j < 4; j++) w[40+j] = k10[127-32*j -: 32];
    for (int i = 39; i >= 0; i--) w[i] = w[i+4] ^ temp_word(w[i+3], i + 4);
    for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] fwd_last(input logic [127:0] k0);
    logic [31:0] w [44];
    for (int j = 0; j < 4; j++) w[j] = k0[127-32*j -: 32];
    for (int i = 4; i < 44; i++) w[i] = w[i-4] ^ temp_word(w[i-1], i);
    return {w[40], w[41], w[42], w[43]};
  endfunction

  task automatic start_sched(input logic [127:0] k);
    start     = 1'b1;
    key_in    = k;
    key_ready = 1'b0;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Consume all 11 keys with key_ready high pct% of cycles, checking order and hold.
  task automatic drain(input logic [127:0] k10, input int pct, input int inject_round,
                       input bit b2b, input logic [127:0] next_key);
    int           er = 10;
    int           cyc = 0;
    bit           stalled = 1'b0;
    bit           injected = 1'b0;
    logic [127:0] pk = '0;
    logic [3:0]   pr = '0;
    compute_ref(k10);
    while (er >= 0) begin
      if (cyc > 400) begin
        chk("drain_timeout", 128'(cyc), 128'd400);
        break;
      end
      chk("valid_high", 128'(key_valid), 128'd1);
      chk("busy_high", 128'(busy), 128'd1);
      chk("done_low", 128'(done), 128'd0);
      if (stalled) begin
        chk("hold_key", key_out, pk);
        chk("hold_round", 128'(round_out), 128'(pr));
      end
      start = 1'b0;
      if (inject_round >= 0 && !injected && int'(round_out) == inject_round) begin
        start    = 1'b1;
        key_in   = '1;
        injected = 1'b1;
      end
      key_ready = ($urandom_range(0, 99) < pct);
      if (key_ready) begin
        chk("round", 128'(round_out), 128'(er));
        chk("key", key_out, ref_rk[er]);
        cap[er] = key_out;
        er--;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pk = key_out;
        pr = round_out;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", 128'(done), 128'd1);
    chk("valid_off", 128'(key_valid), 128'd0);
    chk("busy_off", 128'(busy), 128'd0);
    chk("final_key", key_out, ref_rk[0]);
    chk("final_round", 128'(round_out), 128'd0);
    key_ready = 1'b0;
    if (b2b) begin
      start  = 1'b1;
      key_in = next_key;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_once", 128'(done), 128'd0);
    if (b2b) begin
      chk("b2b_valid", 128'(key_valid), 128'd1);
      chk("b2b_round", 128'(round_out), 128'd10);
      chk("b2b_key", key_out, next_key);
    end else begin
      chk("idle_valid", 128'(key_valid), 128'd0);
    end
  endtask

  localparam logic [127:0] A1_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    vecs[0] = '{A1_K10, 10, A1_K10};
    vecs[1] = '{A1_K10, 9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[2] = '{A1_K10, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[3] = '{A1_K10, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[4] = '{128'hb4ef5bcb3e92e21123e951cf6f8f188e, 0, 128'h0};
    vecs[5] = '{128'hb4ef5bcb3e92e21123e951cf6f8f188e, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    build_tables();

    repeat (2) @(negedge clk);
    chk("rst_key", key_out, 128'h0);
    chk("rst_round", 128'(round_out), 128'd0);
    chk("rst_valid", 128'(key_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    rst = 1'b1;
    @(negedge clk);

    // Known-answer vectors, full throughput.
    for (int v = 0; v < 6; v++) begin
      start_sched(vecs[v].k10);
      drain(vecs[v].k10, 100, -1, 1'b0, '0);
      chk("table", cap[vecs[v].round], vecs[v].expect_key);
    end

    // Backpressure on the FIPS key.
    start_sched(A1_K10);
    drain(A1_K10, 45, -1, 1'b0, '0);
    chk("bp_round0", cap[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // All-zero round-10 key: expanding the recovered cipher key must land on zero.
    start_sched(128'h0);
    drain(128'h0, 100, -1, 1'b0, '0);
    chk("zero_roundtrip", fwd_last(cap[0]), 128'h0);

    // start while busy must be ignored.
    start_sched(A1_K10);
    drain(A1_K10, 70, 6, 1'b0, '0);

    // Asynchronous reset mid-schedule.
    start_sched(A1_K10);
    key_ready = 1'b1;
    for (int c = 0; c < 20 && round_out != 4'd4; c++) @(negedge clk);
    chk("reached_r4", 128'(round_out), 128'd4);
    key_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 128'(key_valid), 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_done", 128'(done), 128'd0);
    chk("arst_key", key_out, 128'h0);
    @(negedge clk);
    chk("arst_no_done", 128'(done), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    start_sched(A1_K10);
    drain(A1_K10, 100, -1, 1'b0, '0);

    // Back-to-back: start in the done cycle.
    start_sched(A1_K10);
    drain(A1_K10, 100, -1, 1'b1, 128'h0123456789abcdeffedcba9876543210);
    drain(128'h0123456789abcdeffedcba9876543210, 100, -1, 1'b0, '0);

    // Random keys with random backpressure.
    for (int n = 0; n < 12; n++) begin
      logic [127:0] k;
      k = {$urandom, $urandom, $urandom, $urandom};
      start_sched(k);
      drain(k, int'($urandom_range(40, 100)), -1, 1'b0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
